// File: rtl/mux_n_reg.sv
// N-input, W-bit registered multiplexer with valid/ready on every port.
// Channel selection is either fixed (SEL) or round-robin over valid inputs.
module mux_n_reg #(
    parameter  int unsigned N  = 2,
    parameter  int unsigned W  = 1,
    localparam int unsigned SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic [N*W-1:0]  IN_DATA,
    input  logic [N-1:0]    IN_VALID,
    output logic [N-1:0]    IN_READY,
    input  logic [SW-1:0]   SEL,
    input  logic            MODE,
    output logic [W-1:0]    OUT_DATA,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [SW-1:0]   OUT_CH
);

    logic [W-1:0]  data_q, data_d;
    logic          valid_q, valid_d;
    logic [SW-1:0] ch_q, ch_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic [W-1:0]  ch_data [N];
    logic [W-1:0]  grant_data;
    logic [SW-1:0] grant;
    logic          grant_vld;
    logic          load;
    logic          xfer;
    logic [SW:0]   idx;

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign ch_data[g] = IN_DATA[g*W +: W];
    end

    assign load = !valid_q || OUT_READY;

    // Grant selection: SEL in fixed mode, first valid channel from PTR upward otherwise.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        idx       = '0;
        if (!MODE) begin
            if ({1'b0, SEL} < (SW+1)'(N)) begin
                grant_vld = 1'b1;
                grant     = SEL;
            end
        end else begin
            for (int unsigned k = 0; k < N; k++) begin
                idx = {1'b0, ptr_q} + (SW+1)'(k);
                if (idx >= (SW+1)'(N)) begin
                    idx = idx - (SW+1)'(N);
                end
                if (!grant_vld && IN_VALID[idx[SW-1:0]]) begin
                    grant_vld = 1'b1;
                    grant     = idx[SW-1:0];
                end
            end
        end
    end

    // Ready is gated by reset so producers never see a handshake while the register is cleared.
    always_comb begin
        IN_READY = '0;
        if (grant_vld && load && RESET_N) begin
            IN_READY[grant] = 1'b1;
        end
    end

    assign xfer       = |(IN_VALID & IN_READY);
    assign grant_data = ch_data[grant];

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ch_d    = ch_q;
        ptr_d   = ptr_q;
        if (load) begin
            valid_d = xfer;
            if (xfer) begin
                data_d = grant_data;
                ch_d   = grant;
            end
        end
        if (xfer && MODE) begin
            ptr_d = ({1'b0, grant} == (SW+1)'(N - 1)) ? '0 : grant + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ch_q    <= '0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
        end
    end

    assign OUT_DATA  = data_q;
    assign OUT_VALID = valid_q;
    assign OUT_CH    = ch_q;

endmodule

// File: tb/tb_mux_n_reg.sv
// Scoreboard bench for mux_n_reg: an N=4/W=8 instance for the main scenarios
// and an N=3/W=8 instance for the out-of-range SEL case.
module tb_mux_n_reg;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] data;
    } exp_t;

    logic        CLK;
    logic        RESET_N;

    logic [31:0] IN_DATA;
    logic [3:0]  IN_VALID;
    logic [3:0]  IN_READY;
    logic [1:0]  SEL;
    logic        MODE;
    logic [7:0]  OUT_DATA;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [1:0]  OUT_CH;

    logic [23:0] IN_DATA3;
    logic [2:0]  IN_VALID3;
    logic [2:0]  IN_READY3;
    logic [1:0]  SEL3;
    logic        MODE3;
    logic [7:0]  OUT_DATA3;
    logic        OUT_VALID3;
    logic        OUT_READY3;
    logic [1:0]  OUT_CH3;

    int   n_tests;
    int   n_fail;
    exp_t q[$];
    exp_t e;

    mux_n_reg #(.N(4), .W(8)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .IN_DATA   (IN_DATA),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .SEL       (SEL),
        .MODE      (MODE),
        .OUT_DATA  (OUT_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_CH    (OUT_CH)
    );

    mux_n_reg #(.N(3), .W(8)) dut3 (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .IN_DATA   (IN_DATA3),
        .IN_VALID  (IN_VALID3),
        .IN_READY  (IN_READY3),
        .SEL       (SEL3),
        .MODE      (MODE3),
        .OUT_DATA  (OUT_DATA3),
        .OUT_VALID (OUT_VALID3),
        .OUT_READY (OUT_READY3),
        .OUT_CH    (OUT_CH3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic test_reset();
        RESET_N   = 1'b0;
        IN_DATA   = '0;
        IN_VALID  = '0;
        SEL       = '0;
        MODE      = 1'b0;
        OUT_READY = 1'b0;
        IN_DATA3  = '0;
        IN_VALID3 = '0;
        SEL3      = '0;
        MODE3     = 1'b0;
        OUT_READY3 = 1'b0;
        repeat (2) @(negedge CLK);
        RESET_N  = 1'b1;
        IN_DATA[7:0] = 8'hA5;
        IN_VALID = 4'b0001;
        @(negedge CLK);
        n_tests++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'hA5) begin
            n_fail++;
            $display("FAIL reset_preload: got v=%0b data=%h, expected v=1 data=a5", OUT_VALID, OUT_DATA);
        end
        #2 RESET_N = 1'b0;
        #1;
        n_tests++;
        if (OUT_VALID !== 1'b0 || OUT_DATA !== 8'h00 || OUT_CH !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_async: got v=%0b data=%h ch=%0d, expected 0/00/0", OUT_VALID, OUT_DATA, OUT_CH);
        end
        n_tests++;
        if (IN_READY !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, expected 0000", IN_READY);
        end
        @(negedge CLK);
        IN_VALID = '0;
        RESET_N  = 1'b1;
        #1;
        MODE      = 1'b1;
        IN_VALID  = 4'hF;
        OUT_READY = 1'b1;
        #1;
        n_tests++;
        if (IN_READY !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_ptr: got in_ready=%b, expected 0001", IN_READY);
        end
        IN_VALID = '0;
        MODE     = 1'b0;
    endtask

    task automatic test_fixed_select();
        @(negedge CLK);
        MODE      = 1'b0;
        SEL       = 2'd2;
        OUT_READY = 1'b1;
        IN_DATA   = {8'h4D, 8'h3C, 8'h2B, 8'h1A};
        IN_VALID  = 4'hF;
        q.push_back('{ch: 2'd2, data: 8'h3C});
        #1;
        n_tests++;
        if (IN_READY !== 4'b0100) begin
            n_fail++;
            $display("FAIL fixed_ready: got %b, expected 0100", IN_READY);
        end
        @(negedge CLK);
        n_tests++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL fixed_out: scoreboard underflow");
        end else begin
            e = q.pop_front();
            if (OUT_VALID !== 1'b1 || OUT_CH !== e.ch || OUT_DATA !== e.data) begin
                n_fail++;
                $display("FAIL fixed_out: got v=%0b ch=%0d data=%h, expected v=1 ch=%0d data=%h",
                         OUT_VALID, OUT_CH, OUT_DATA, e.ch, e.data);
            end
        end
        IN_VALID = '0;
        #1;
        n_tests++;
        if (IN_READY !== 4'b0100) begin
            n_fail++;
            $display("FAIL fixed_ready_novalid: got %b, expected 0100", IN_READY);
        end
        @(negedge CLK);
        n_tests++;
        if (OUT_VALID !== 1'b0 || OUT_DATA !== 8'h3C || OUT_CH !== 2'd2) begin
            n_fail++;
            $display("FAIL fixed_drain: got v=%0b ch=%0d data=%h, expected v=0 ch=2 data=3c",
                     OUT_VALID, OUT_CH, OUT_DATA);
        end
    endtask

    task automatic test_back_pressure();
        MODE      = 1'b0;
        SEL       = 2'd2;
        OUT_READY = 1'b1;
        IN_DATA   = 32'h0;
        IN_DATA[23:16] = 8'h01;
        IN_VALID  = 4'b0100;
        q.push_back('{ch: 2'd2, data: 8'h01});
        @(negedge CLK);
        n_tests++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL bp_first: scoreboard underflow");
        end else begin
            e = q.pop_front();
            if (OUT_VALID !== 1'b1 || OUT_CH !== e.ch || OUT_DATA !== e.data) begin
                n_fail++;
                $display("FAIL bp_first: got v=%0b ch=%0d data=%h, expected v=1 ch=%0d data=%h",
                         OUT_VALID, OUT_CH, OUT_DATA, e.ch, e.data);
            end
        end
        OUT_READY = 1'b0;
        IN_DATA[23:16] = 8'h02;
        q.push_back('{ch: 2'd2, data: 8'h02});
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (IN_READY !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_stall_ready[%0d]: got %b, expected 0000", i, IN_READY);
            end
            @(negedge CLK);
            n_tests++;
            if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h01) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%0b data=%h, expected v=1 data=01", i, OUT_VALID, OUT_DATA);
            end
        end
        OUT_READY = 1'b1;
        #1;
        n_tests++;
        if (IN_READY !== 4'b0100) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %b, expected 0100", IN_READY);
        end
        @(negedge CLK);
        n_tests++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL bp_second: scoreboard underflow");
        end else begin
            e = q.pop_front();
            if (OUT_VALID !== 1'b1 || OUT_CH !== e.ch || OUT_DATA !== e.data) begin
                n_fail++;
                $display("FAIL bp_second: got v=%0b ch=%0d data=%h, expected v=1 ch=%0d data=%h",
                         OUT_VALID, OUT_CH, OUT_DATA, e.ch, e.data);
            end
        end
        IN_VALID = '0;
        @(negedge CLK);
        n_tests++;
        if (OUT_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_dup: got v=%0b, expected 0", OUT_VALID);
        end
    endtask

    task automatic test_round_robin();
        MODE      = 1'b1;
        OUT_READY = 1'b1;
        IN_DATA   = {8'h13, 8'h12, 8'h11, 8'h10};
        IN_VALID  = 4'hF;
        for (int i = 0; i < 5; i++) begin
            q.push_back('{ch: 2'(i % 4), data: 8'(8'h10 + (i % 4))});
            @(negedge CLK);
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL rr_seq[%0d]: scoreboard underflow", i);
            end else begin
                e = q.pop_front();
                if (OUT_VALID !== 1'b1 || OUT_CH !== e.ch || OUT_DATA !== e.data) begin
                    n_fail++;
                    $display("FAIL rr_seq[%0d]: got v=%0b ch=%0d data=%h, expected v=1 ch=%0d data=%h",
                             i, OUT_VALID, OUT_CH, OUT_DATA, e.ch, e.data);
                end
            end
        end
        IN_VALID = '0;
        @(negedge CLK);
        n_tests++;
        if (OUT_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_drain: got v=%0b, expected 0", OUT_VALID);
        end
    endtask

    task automatic test_rr_skip_wrap();
        // PTR is 1 here; serving ch2 moves it to 3.
        MODE      = 1'b1;
        OUT_READY = 1'b1;
        IN_VALID  = 4'b0100;
        q.push_back('{ch: 2'd2, data: 8'h12});
        @(negedge CLK);
        n_tests++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL rr_skip_ch2: scoreboard underflow");
        end else begin
            e = q.pop_front();
            if (OUT_VALID !== 1'b1 || OUT_CH !== e.ch || OUT_DATA !== e.data) begin
                n_fail++;
                $display("FAIL rr_skip_ch2: got v=%0b ch=%0d data=%h, expected v=1 ch=%0d data=%h",
                         OUT_VALID, OUT_CH, OUT_DATA, e.ch, e.data);
            end
        end
        IN_VALID = 4'b0010;
        q.push_back('{ch: 2'd1, data: 8'h11});
        #1;
        n_tests++;
        if (IN_READY !== 4'b0010) begin
            n_fail++;
            $display("FAIL rr_wrap_ready: got %b, expected 0010", IN_READY);
        end
        @(negedge CLK);
        n_tests++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL rr_wrap_out: scoreboard underflow");
        end else begin
            e = q.pop_front();
            if (OUT_VALID !== 1'b1 || OUT_CH !== e.ch || OUT_DATA !== e.data) begin
                n_fail++;
                $display("FAIL rr_wrap_out: got v=%0b ch=%0d data=%h, expected v=1 ch=%0d data=%h",
                         OUT_VALID, OUT_CH, OUT_DATA, e.ch, e.data);
            end
        end
        IN_VALID = 4'hF;
        #1;
        n_tests++;
        if (IN_READY !== 4'b0100) begin
            n_fail++;
            $display("FAIL rr_ptr_after_wrap: got %b, expected 0100", IN_READY);
        end
        IN_VALID = '0;
        @(negedge CLK);
    endtask

    task automatic test_sel_out_of_range();
        MODE3      = 1'b0;
        SEL3       = 2'd2;
        OUT_READY3 = 1'b1;
        IN_DATA3   = {8'h77, 8'h66, 8'h55};
        IN_VALID3  = 3'b100;
        @(negedge CLK);
        n_tests++;
        if (OUT_VALID3 !== 1'b1 || OUT_DATA3 !== 8'h77 || OUT_CH3 !== 2'd2) begin
            n_fail++;
            $display("FAIL n3_load: got v=%0b ch=%0d data=%h, expected v=1 ch=2 data=77",
                     OUT_VALID3, OUT_CH3, OUT_DATA3);
        end
        SEL3      = 2'd3;
        IN_VALID3 = 3'b111;
        #1;
        n_tests++;
        if (IN_READY3 !== 3'b000) begin
            n_fail++;
            $display("FAIL n3_sel3_ready: got %b, expected 000", IN_READY3);
        end
        @(negedge CLK);
        n_tests++;
        if (OUT_VALID3 !== 1'b0 || OUT_DATA3 !== 8'h77) begin
            n_fail++;
            $display("FAIL n3_sel3_drain: got v=%0b data=%h, expected v=0 data=77", OUT_VALID3, OUT_DATA3);
        end
        IN_VALID3 = '0;
    endtask

    task automatic test_mode_switch();
        // PTR is 2 here; only ch1 valid so ch1 is granted and PTR stays 2.
        MODE      = 1'b1;
        OUT_READY = 1'b0;
        IN_DATA   = {8'h00, 8'h00, 8'h5A, 8'h66};
        IN_VALID  = 4'b0010;
        q.push_back('{ch: 2'd1, data: 8'h5A});
        @(negedge CLK);
        n_tests++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL ms_held: scoreboard underflow");
        end else begin
            e = q.pop_front();
            if (OUT_VALID !== 1'b1 || OUT_CH !== e.ch || OUT_DATA !== e.data) begin
                n_fail++;
                $display("FAIL ms_held: got v=%0b ch=%0d data=%h, expected v=1 ch=%0d data=%h",
                         OUT_VALID, OUT_CH, OUT_DATA, e.ch, e.data);
            end
        end
        MODE     = 1'b0;
        SEL      = 2'd0;
        IN_VALID = 4'hF;
        #1;
        n_tests++;
        if (IN_READY !== 4'b0000) begin
            n_fail++;
            $display("FAIL ms_stall_ready: got %b, expected 0000", IN_READY);
        end
        @(negedge CLK);
        n_tests++;
        if (OUT_VALID !== 1'b1 || OUT_CH !== 2'd1 || OUT_DATA !== 8'h5A) begin
            n_fail++;
            $display("FAIL ms_hold_unchanged: got v=%0b ch=%0d data=%h, expected v=1 ch=1 data=5a",
                     OUT_VALID, OUT_CH, OUT_DATA);
        end
        OUT_READY = 1'b1;
        q.push_back('{ch: 2'd0, data: 8'h66});
        #1;
        n_tests++;
        if (IN_READY !== 4'b0001) begin
            n_fail++;
            $display("FAIL ms_ready_ch0: got %b, expected 0001", IN_READY);
        end
        @(negedge CLK);
        n_tests++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL ms_next_ch0: scoreboard underflow");
        end else begin
            e = q.pop_front();
            if (OUT_VALID !== 1'b1 || OUT_CH !== e.ch || OUT_DATA !== e.data) begin
                n_fail++;
                $display("FAIL ms_next_ch0: got v=%0b ch=%0d data=%h, expected v=1 ch=%0d data=%h",
                         OUT_VALID, OUT_CH, OUT_DATA, e.ch, e.data);
            end
        end
        IN_VALID = '0;
        MODE     = 1'b1;
        IN_VALID = 4'hF;
        #1;
        n_tests++;
        if (IN_READY !== 4'b0100) begin
            n_fail++;
            $display("FAIL ms_ptr_kept: got %b, expected 0100", IN_READY);
        end
        IN_VALID = '0;
        @(negedge CLK);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %0d entries left, expected 0", q.size());
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_fixed_select();
        test_back_pressure();
        test_round_robin();
        test_rr_skip_wrap();
        test_sel_out_of_range();
        test_mode_switch();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_n_reg.md
Name: mux_n_reg

Overview:
- Parametrised N-input, W-bit registered multiplexer with a valid/ready handshake on every input and on the output.
- Generational successor to the team's single-bit 2:1 gate-level MUX.
- Two channel-selection modes: fixed select (SEL-driven) and round-robin over valid inputs.
- Sits between multiple data producers and one consumer in the lab datapaths; one register stage, no combinational path from inputs to output data.

Parameters:
- N, default 2, number of input channels (N >= 2).
- W, default 1, data width per channel in bits (W >= 1).
- SW, localparam = clog2(N), width of SEL and OUT_CH.

Ports:
- CLK  input  1  rising-edge clock.
- RESET_N  input  1  asynchronous, active-low reset.
- IN_DATA  input  N*W  channel i occupies bits [i*W +: W].
- IN_VALID  input  N  per-channel valid.
- IN_READY  output  N  per-channel ready (combinational).
- SEL  input  SW  channel index, used in MODE=0.
- MODE  input  1  0 = fixed select, 1 = round-robin.
- OUT_DATA  output  W  registered selected data.
- OUT_VALID  output  1  registered output valid.
- OUT_READY  input  1  consumer ready.
- OUT_CH  output  SW  index of the channel that produced OUT_DATA.

Behaviour:
- Reset (RESET_N low, asynchronous): OUT_DATA=0, OUT_VALID=0, OUT_CH=0, round-robin pointer PTR=0. IN_READY is 0 while reset is asserted. Reset mid-transfer discards the held word.
- Load enable: LOAD = !OUT_VALID || OUT_READY.
- Grant:
  - MODE=0: G = SEL.
  - MODE=1: G = first index with IN_VALID set, scanning PTR, PTR+1, …, N-1, 0, …, PTR-1 (wrap).
  - No grant if no valid channel, or if SEL >= N (non-power-of-two N).
- IN_READY[G] = LOAD when a grant exists. All other IN_READY bits are 0. IN_READY never depends on the IN_VALID of the same channel in MODE=0.
- Input transfer: occurs on a rising edge where IN_VALID[G] && IN_READY[G]. On that edge: OUT_DATA <= channel G data, OUT_CH <= G, OUT_VALID <= 1.
- Drain: when LOAD && !transfer, OUT_VALID <= 0 on the edge, and OUT_DATA/OUT_CH hold their old values.
- Stall: when OUT_VALID && !OUT_READY, all output registers hold.
- Throughput and latency:
  - Latency is exactly 1 cycle from input transfer to OUT_VALID.
  - Full throughput of 1 word per cycle when OUT_READY is held high.
- PTR update: only in MODE=1, only on an input transfer; PTR <= (G == N-1) ? 0 : G+1. PTR holds in MODE=0.
- Mode/select changes:
  - MODE and SEL changes take effect combinationally for the next grant.
  - A word already held in the output register is unaffected.
  - Switching MODE does not reset PTR.
- Simultaneous events:
  - Output drain and new input load on the same edge: legal, no bubble.
  - All N inputs valid in MODE=1: each channel is served once per N transfers.
- No data is ever duplicated or dropped. An input word is consumed only on its handshake edge.

Test Plan:
- Reset: RESET_N=0 asynchronously mid-cycle, with OUT_VALID=1 and OUT_DATA=0xA5 -> outputs go immediately to 0/0/0, IN_READY=0. After release, PTR=0.
- Fixed select (N=4, W=8, MODE=0, SEL=2, IN_DATA ch2=0x3C valid, OUT_READY=1) -> next cycle OUT_DATA=0x3C, OUT_CH=2, OUT_VALID=1. IN_READY=4'b0100 throughout.
- Back-pressure: OUT_VALID=1 with OUT_READY=0 for 3 cycles while ch2 streams 0x01, 0x02 -> OUT_DATA holds 0x01 and IN_READY=0. On release, 0x02 appears the next cycle with no loss and no duplication.
- Round-robin (MODE=1, all 4 channels valid with data 0x10/0x11/0x12/0x13, OUT_READY=1) -> OUT_CH sequence 0,1,2,3,0. OUT_DATA is 0x10, 0x11, 0x12, 0x13, 0x10 (next word from ch0).
- Round-robin skip and wrap (PTR=3, only ch1 valid) -> grant 1, PTR becomes 2. With N=3 and SEL=3 in MODE=0 -> IN_READY=0 and OUT_VALID drops after drain.
- Mode switch: while OUT_VALID=1 is stalled holding ch1 data, change MODE 1→0 with SEL=0 -> the held word is output unchanged, and the next transfer comes from ch0.
